window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Producer side for the 9-input adder tree: converts a raster-order pixel/activation stream into 3x3 windows.
- Each window is presented as a packed 9xWIDTH vector, in the same layout the adder tree / MAC stage consumes on its indata port.
- Sits between the input feature-map stream and the multiply/adder-tree stage of the convolution datapath.
- Emits only fully-valid windows (no padding): (IMG_W-2)*(IMG_H-2) windows per frame.

Parameters:
- WIDTH, 32, bit width of one pixel/tap.
- IMG_W, 8, pixels per row; must be >= 3.
- IMG_H, 8, rows per frame; must be >= 3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  source has a pixel on in_data.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WIDTH  pixel, raster order (row-major, left to right).
- out_valid  out  1  window holds a valid 3x3 window.
- out_ready  in  1  consumer takes the window this cycle.
- window  out  [9][WIDTH] packed  taps; index 3*r+c, with r=0 the oldest (top) row and c=0 the leftmost column; index 8 is the newest pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst low, async): out_valid=0, window=0, frame_done=0, col=0, row=0, 3x3 tap registers=0. Line-buffer storage is not reset; its contents are never observable.
- Accept: occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This gives a single output register with full throughput; in_ready is combinational from out_ready.
- On each accept:
  - Each tap row shifts left by one.
  - Column 2 is loaded with {line_buf1 output, line_buf0 output, in_data} for rows 0, 1, 2.
  - line_buf0 pushes in_data; line_buf1 pushes line_buf0's output. Each buffer is IMG_W deep, shift-on-accept.
- Window qualification: the accepted pixel completes a window iff row >= 2 && col >= 2, using the counters before update.
  - If it qualifies, on the next edge: out_valid=1 and window is loaded with the updated taps.
  - Latency is 1 cycle from accept to out_valid.
- Output hold: while out_valid && !out_ready, window and out_valid are stable and in_ready=0.
- Output release: on out_valid && out_ready, out_valid drops unless a new qualifying pixel is accepted in the same cycle. That pixel is accepted because in_ready=1, and window is reloaded back-to-back.
- Counters:
  - col increments on accept and wraps from IMG_W-1 to 0, at which point row increments.
  - When row=IMG_H-1 and col=IMG_W-1 are accepted, both wrap to 0 and frame_done=1 for exactly the next cycle.
  - Counter widths are $clog2(IMG_W) and $clog2(IMG_H).
- Frames are back-to-back with no gap required. Stale previous-frame data in the line buffers and taps is harmless because rows 0-1 never qualify.
- in_valid bubbles: no state changes on non-accept cycles.
- Reset mid-frame: counters restart at 0 and any pending window is dropped (out_valid=0). The next pixel is treated as frame pixel (0,0).
- No arithmetic is performed; data passes through unchanged.

Decomposition:
- conv_pkg:
  - localparams KSIZE=3 and KTAPS=9.
  - typedef tap_vec_t = logic [KTAPS-1:0][WIDTH-1:0]. WIDTH is taken from the package default of 32; the block parameter must match it.
- Sub-module line_buffer (DEPTH, WIDTH; ports clk, rst, shift_en, din, dout):
  - Circular register array with a write pointer.
  - dout is the entry written DEPTH accepts ago.
  - Instantiated twice.

Test Plan (IMG_W=4, IMG_H=4, WIDTH=32 unless noted):
- Streaming, out_ready=1, in_valid=1, pixels 0..15:
  - Exactly 4 windows are produced.
  - First window appears 1 cycle after pixel 10 is accepted: window[0..8]={0,1,2,4,5,6,8,9,10}.
  - Last window: {5,6,7,9,10,11,13,14,15}.
  - frame_done pulses once, 1 cycle after pixel 15 is accepted.
- Backpressure: out_ready=0 for 5 cycles after the first window.
  - window stays {0,1,2,4,5,6,8,9,10} and in_ready=0.
  - Pixel 11 is not consumed until out_ready=1.
  - Then the second window is {1,2,3,5,6,7,9,10,11}.
- Random in_valid bubbles (~50%) and random out_ready:
  - The window sequence is identical to scenario 1.
  - No window is lost or duplicated.
- Back-to-back frames 0..15 then 16..31:
  - No output during pixels 16..25.
  - Frame 2 first window = {16,17,18,20,21,22,24,25,26}.
  - frame_done pulses twice.
- Reset mid-frame: drive rst low asynchronously after pixel 6, release, then stream 0..15.
  - out_valid=0 immediately on reset.
  - Afterwards the results match scenario 1 exactly.
- Integration, IMG_W=5, IMG_H=3: feed window into the adder tree with an all-ones frame.
  - 3 windows are produced.
  - Each adder-tree result = 9 after the adder-tree latency.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath (window generator -> adder tree).
package conv_pkg;

  // Kernel geometry: 3x3 window, 9 taps.
  localparam int unsigned KSIZE = 3;
  localparam int unsigned KTAPS = KSIZE * KSIZE;

  // Tap width used across the datapath; block-level WIDTH parameters must match.
  localparam int unsigned TAP_WIDTH = 32;

  // Packed tap vector in the layout the adder tree consumes: index 3*r+c.
  typedef logic [KTAPS-1:0][TAP_WIDTH-1:0] tap_vec_t;

  // Flat tap index for row r (0 = oldest) and column c (0 = leftmost).
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Shift-on-enable delay line of DEPTH entries built as a circular register array.
// dout always shows the entry written DEPTH enables ago.
module line_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;

  // The slot about to be overwritten is the oldest one, so it is the output.
  assign dout = mem_q[wr_ptr_q];

  // Storage is deliberately not reset: only entries written this frame are ever used.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Write pointer advances on every enable and wraps at DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
    end else if (shift_en) begin
      if (wr_ptr_q == PtrW'(DEPTH - 1)) begin
        wr_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster stream to 3x3 window generator feeding the 9-input adder tree.
// Two line buffers supply the two previous rows; a 3x3 tap array shifts left per pixel.
// Only fully-valid windows are emitted, through a single output register with
// full-throughput ready/valid handshaking.
module window_gen_3x3
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output tap_vec_t         window,
  output logic             frame_done
);

  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);

  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;
  tap_vec_t         taps_q;
  tap_vec_t         taps_d;
  tap_vec_t         window_q;
  logic             out_valid_q;
  logic             frame_done_q;
  logic [WIDTH-1:0] lb0_dout;
  logic [WIDTH-1:0] lb1_dout;
  logic             accept;
  logic             qualify;
  logic             col_last;
  logic             row_last;

  // Free to accept whenever the output register is empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign col_last = (col_q == ColW'(IMG_W - 1));
  assign row_last = (row_q == RowW'(IMG_H - 1));
  // Uses pre-update counters: the pixel completes a window once two full rows
  // and two earlier columns exist in the current frame.
  assign qualify  = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  assign out_valid  = out_valid_q;
  assign window     = window_q;
  assign frame_done = frame_done_q;

  // Row-1 history: delays the input by exactly one image row.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (WIDTH)
  ) u_line_buf0 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (in_data),
    .dout     (lb0_dout)
  );

  // Row-2 history: chained after line_buf0, so two rows of delay in total.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (WIDTH)
  ) u_line_buf1 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .din      (lb0_dout),
    .dout     (lb1_dout)
  );

  // Next tap state: shift every row left, load the new column from buffers and input.
  always_comb begin
    taps_d = taps_q;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE - 1; c++) begin
        taps_d[tap_idx(r, c)] = taps_q[tap_idx(r, c + 1)];
      end
    end
    taps_d[tap_idx(0, KSIZE - 1)] = lb1_dout;
    taps_d[tap_idx(1, KSIZE - 1)] = lb0_dout;
    taps_d[tap_idx(2, KSIZE - 1)] = in_data;
  end

  // Tap array only moves on accepted pixels; bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps_q <= '0;
    end else if (accept) begin
      taps_q <= taps_d;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Output register: load on a qualifying accept, else drain when the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      window_q    <= '0;
    end else if (accept && qualify) begin
      out_valid_q <= 1'b1;
      window_q    <= taps_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle pulse after the last pixel of the frame is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && row_last && col_last;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: table-driven frame checks, hand-written corner sequences,
// randomized handshakes, all scored against a frame-array reference model.
module tb_window_gen_3x3;
  import conv_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NV   = 3;

  localparam int unsigned FIRST_OFF[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  localparam int unsigned SECOND_OFF[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  localparam int unsigned LAST_OFF[9]   = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [31:0] in_data;
  tap_vec_t    window;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
  logic [31:0] in_data2;
  tap_vec_t    window2;

  always #5 clk = ~clk;

  window_gen_3x3 #(
    .WIDTH (32),
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .window     (window),
    .frame_done (frame_done)
  );

  window_gen_3x3 #(
    .WIDTH (32),
    .IMG_W (5),
    .IMG_H (3)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_data    (in_data2),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .window     (window2),
    .frame_done (frame_done2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_int(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_win(input string name, input tap_vec_t got, input tap_vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic tap_vec_t mkw(input logic [31:0] base, input int unsigned off[9]);
    tap_vec_t w;
    for (int k = 0; k < 9; k++) w[k] = base + off[k];
    return w;
  endfunction

  // ---------------- reference model (frame array + queues) ----------------
  logic [31:0] frame_px [NPIX];
  int          pos;
  bit          exp_valid;
  bit          exp_fd;
  int          fd_count;
  tap_vec_t    exp_q [$];
  tap_vec_t    got_q [$];

  always @(negedge clk) begin
    bit       acc, cons;
    int       r, c;
    tap_vec_t w;
    if (!rst) begin
      pos       = 0;
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      exp_q.delete();
      check_int("reset_out_valid", out_valid, 0);
    end else begin
      check_int("out_valid", out_valid, exp_valid);
      check_int("frame_done", frame_done, exp_fd);
      check_int("in_ready", in_ready, !exp_valid || out_ready);
      if (frame_done === 1'b1) fd_count++;
      // A presented window is always the oldest not-yet-consumed one.
      if (exp_valid && exp_q.size() > 0) check_win("window_presented", window, exp_q[0]);
      cons = exp_valid && out_ready;
      if (cons) begin
        if (exp_q.size() == 0) check_int("window_unexpected", 1, 0);
        else void'(exp_q.pop_front());
        got_q.push_back(window);
      end
      acc    = in_valid && (!exp_valid || out_ready);
      exp_fd = 1'b0;
      if (acc) begin
        r = pos / W;
        c = pos % W;
        frame_px[pos] = in_data;
        if (r >= 2 && c >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[3*i+j] = frame_px[(r-2+i)*W + (c-2+j)];
          exp_q.push_back(w);
          exp_valid = 1'b1;
        end else if (cons) begin
          exp_valid = 1'b0;
        end
        exp_fd = (pos == NPIX - 1);
        pos    = (pos + 1) % NPIX;
      end else if (cons) begin
        exp_valid = 1'b0;
      end
    end
  end

  // Integration consumer: all-ones frame must sum to 9 per window.
  int n_win2 = 0;
  always @(negedge clk) begin
    longint sum;
    if (rst && out_valid2 && out_ready2) begin
      sum = 0;
      for (int k = 0; k < 9; k++) sum += window2[k];
      check_int("adder_sum", sum, 9);
      n_win2++;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit iv, input logic [31:0] d, input bit ordy, output bit acc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    acc = iv && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    bit a;
    drive(1'b1, d, 1'b1, a);
  endtask

  task automatic flush();
    bit a;
    repeat (2) drive(1'b0, '0, 1'b1, a);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check_int("rst_out_valid", out_valid, 0);
    check_int("rst_frame_done", frame_done, 0);
    check_win("rst_window", window, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] base;
    int          n_win;
    tap_vec_t    first_w;
    tap_vec_t    last_w;
  } vec_t;

  vec_t vecs [NV];
  int   fd0;

  task automatic check_frame(input string tag, input vec_t v, input int fd_exp);
    check_int({tag, "_count"}, got_q.size(), v.n_win);
    if (got_q.size() > 0) begin
      check_win({tag, "_first"}, got_q[0], v.first_w);
      check_win({tag, "_last"}, got_q[got_q.size()-1], v.last_w);
    end
    check_int({tag, "_frame_done"}, fd_count, fd_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int guard;
    logic [31:0] d;

    rst = 1'b0; in_valid = 0; in_data = '0; out_ready = 0;
    in_valid2 = 0; in_data2 = '0; out_ready2 = 1;
    fd_count = 0;

    vecs[0].base = 32'd0;
    vecs[1].base = 32'd16;
    vecs[2].base = 32'h0abc_0000;
    for (int v = 0; v < NV; v++) begin
      vecs[v].n_win   = 4;
      vecs[v].first_w = mkw(vecs[v].base, FIRST_OFF);
      vecs[v].last_w  = mkw(vecs[v].base, LAST_OFF);
    end

    repeat (2) @(posedge clk);
    #1;
    check_int("reset_valid", out_valid, 0);
    check_win("reset_window", window, '0);
    check_int("reset_frame_done", frame_done, 0);
    rst = 1'b1;

    // Table: back-to-back frames with no gap between them.
    fd0 = fd_count;
    for (int v = 0; v < NV; v++) begin
      for (int p = 0; p < NPIX; p++) begin
        send(vecs[v].base + p);
        if (p == 0) begin
          if (v > 0) check_frame("stream", vecs[v-1], fd0 + v);
          got_q.delete();
        end
        if (p == 9) check_int("no_early_window", got_q.size(), 0);
      end
    end
    flush();
    check_frame("stream", vecs[NV-1], fd0 + NV);

    // Backpressure on the first window.
    got_q.delete();
    for (int p = 0; p <= 10; p++) send(p);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'd11, 1'b0, a);
      check_int("bp_not_accepted", a, 0);
      check_int("bp_valid_held", out_valid, 1);
      check_win("bp_window_held", window, vecs[0].first_w);
    end
    drive(1'b1, 32'd11, 1'b1, a);
    check_int("bp_accept_after_release", a, 1);
    for (int p = 12; p < NPIX; p++) send(p);
    flush();
    check_int("bp_count", got_q.size(), 4);
    if (got_q.size() >= 2) check_win("bp_second", got_q[1], mkw(0, SECOND_OFF));

    // Random bubbles and random backpressure; frame 0 uses 0..15, others random data.
    for (int it = 0; it < 4; it++) begin
      got_q.delete();
      fd0 = fd_count;
      for (int p = 0; p < NPIX; p++) begin
        d = (it == 0) ? 32'(p) : $urandom;
        a = 1'b0;
        guard = 0;
        while (!a && guard < 200) begin
          drive(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), a);
          guard++;
        end
        if (!a) check_int("rand_accept_timeout", guard, 0);
      end
      flush();
      check_int("rand_count", got_q.size(), 4);
      check_int("rand_frame_done", fd_count, fd0 + 1);
      if (it == 0 && got_q.size() == 4) begin
        check_win("rand_first", got_q[0], vecs[0].first_w);
        check_win("rand_second", got_q[1], mkw(0, SECOND_OFF));
        check_win("rand_last", got_q[3], vecs[0].last_w);
      end
    end

    // Reset mid-frame after pixel 6, then a clean frame.
    for (int p = 0; p <= 6; p++) send(p);
    reset_pulse();
    got_q.delete();
    fd0 = fd_count;
    for (int p = 0; p < NPIX; p++) send(p);
    flush();
    check_frame("after_reset", vecs[0], fd0 + 1);

    // Reset while a window is held by backpressure: it must be dropped.
    for (int p = 0; p <= 10; p++) send(p);
    drive(1'b0, '0, 1'b0, a);
    check_int("pending_before_reset", out_valid, 1);
    reset_pulse();
    got_q.delete();
    fd0 = fd_count;
    for (int p = 0; p < NPIX; p++) send(p);
    flush();
    check_frame("after_reset2", vecs[0], fd0 + 1);

    // Integration: 5x3 all-ones frame into the summing consumer.
    n_win2 = 0;
    in_data2  = 32'd1;
    in_valid2 = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_int("integ_windows", n_win2, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
